// File: rtl/craft_pn_sbox_stage.sv
// craft_pn_sbox_stage
//   Back half of the CRAFT round: PermuteNibbles followed by the SubBox layer.
//   One state is latched (PN applied on the way in). The state then goes
//   through a single shared 16-bit S-box lane, one lane per cycle for four
//   cycles. The result is held on a valid/ready output. This uses less logic
//   at the cost of latency. Accept-to-out_valid is 4 cycles. The minimum
//   initiation interval is 6 cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream state available
//   in_ready   stage idle and able to accept
//   in_state   64-bit state, nibble i at [63-4i : 60-4i]
//   out_valid  result available (held until out_ready)
//   out_ready  downstream accepts result
//   out_state  PN+SB result, same nibble order (valid only with out_valid)
//   busy       stage holds a state (SUB or DONE)

// 4-bit CRAFT S-box
module craft_sbox4 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        case (din)
            4'h0: dout = 4'hC;
            4'h1: dout = 4'hA;
            4'h2: dout = 4'hD;
            4'h3: dout = 4'h3;
            4'h4: dout = 4'hE;
            4'h5: dout = 4'hB;
            4'h6: dout = 4'hF;
            4'h7: dout = 4'h7;
            4'h8: dout = 4'h8;
            4'h9: dout = 4'h9;
            4'hA: dout = 4'h1;
            4'hB: dout = 4'h5;
            4'hC: dout = 4'h0;
            4'hD: dout = 4'h2;
            4'hE: dout = 4'h4;
            default: dout = 4'h6;
        endcase
    end
endmodule

// 16-bit S-box lane: four independent 4-bit S-boxes
module craft_sbox16 (
    input  logic [15:0] din,
    output logic [15:0] dout
);
    for (genvar j = 0; j < 4; j++) begin : g_nib
        craft_sbox4 u_sb (
            .din  (din[4*j+3 -: 4]),
            .dout (dout[4*j+3 -: 4])
        );
    end
endmodule

module craft_pn_sbox_stage #(
    parameter int STATE_W   = 64,   // fixed
    parameter int LANE_W    = 16,   // fixed, 4 lanes
    parameter int PN_ENABLE = 1     // 0 = SB only (bypass/test build)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);
    localparam int NUM_LANES = STATE_W / LANE_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Nibble i of this constant is the PN source index P[i].
    localparam logic [63:0] PN_IDX = 64'hFCDE_A98B_6547_1230;

    logic [1:0]         state;
    logic [1:0]         cnt;
    logic [STATE_W-1:0] work;
    logic [STATE_W-1:0] pn_state;
    logic [LANE_W-1:0]  lane_in;
    logic [LANE_W-1:0]  lane_out;

    // PermuteNibbles is pure wiring on the input path.
    if (PN_ENABLE != 0) begin : g_pn
        for (genvar i = 0; i < 16; i++) begin : g_nib
            localparam int SRC = int'(PN_IDX[63-4*i -: 4]);
            assign pn_state[63-4*i -: 4] = in_state[63-4*SRC -: 4];
        end
    end else begin : g_nopn
        assign pn_state = in_state;
    end

    // Lane 0 is the most significant 16 bits.
    always_comb begin
        lane_in = work[STATE_W-1 -: LANE_W];
        for (int l = 0; l < NUM_LANES; l++)
            if (cnt == l[1:0])
                lane_in = work[STATE_W-1-LANE_W*l -: LANE_W];
    end

    craft_sbox16 u_lane (
        .din  (lane_in),
        .dout (lane_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
            work  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        work  <= pn_state;
                        cnt   <= 2'd0;
                        state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    for (int l = 0; l < NUM_LANES; l++)
                        if (cnt == l[1:0])
                            work[STATE_W-1-LANE_W*l -: LANE_W] <= lane_out;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst so all handshake flags are low during the reset cycle,
    // even when reset lands in the middle of SUB.
    assign in_ready  = (state == ST_IDLE) && !rst;
    assign out_valid = (state == ST_DONE) && !rst;
    assign busy      = (state != ST_IDLE) && !rst;
    assign out_state = work;

endmodule

// File: tb/tb_craft_pn_sbox_stage.sv
module tb_craft_pn_sbox_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_state = '0;

    logic        in_ready, out_valid, busy;
    logic [63:0] out_state;
    logic        in_ready_b, out_valid_b, busy_b;
    logic [63:0] out_state_b;

    always #5 clk = ~clk;

    craft_pn_sbox_stage #(.STATE_W(64), .LANE_W(16), .PN_ENABLE(1)) dut_pn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy)
    );

    craft_pn_sbox_stage #(.STATE_W(64), .LANE_W(16), .PN_ENABLE(0)) dut_byp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_state(in_state), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_state(out_state_b), .busy(busy_b)
    );

    typedef struct {
        logic [63:0] din;
        logic [63:0] exp_pn;
        logic [63:0] exp_byp;
    } vec_t;

    typedef struct {
        logic [63:0] exp_pn;
        logic [63:0] exp_byp;
    } exp_t;

    exp_t sb_q[$];
    int total = 0;
    int bad = 0;

    localparam int          P_TB[16] = '{15,12,13,14,10,9,8,11,6,5,4,7,1,2,3,0};
    localparam logic [3:0]  S_TB[16] = '{4'hC,4'hA,4'hD,4'h3,4'hE,4'hB,4'hF,4'h7,
                                         4'h8,4'h9,4'h1,4'h5,4'h0,4'h2,4'h4,4'h6};

    function automatic logic [63:0] model(input logic [63:0] s, input bit pn);
        logic [63:0] t;
        logic [63:0] r;
        for (int i = 0; i < 16; i++)
            t[63-4*i -: 4] = pn ? s[63-4*P_TB[i] -: 4] : s[63-4*i -: 4];
        for (int i = 0; i < 16; i++)
            r[63-4*i -: 4] = S_TB[t[63-4*i -: 4]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every output handshake pops one expected pair.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %h want none", out_state);
            end else begin
                e = sb_q.pop_front();
                chk("out_state_pn", out_state, e.exp_pn);
                chk("out_state_byp", out_state_b, e.exp_byp);
                chk("out_valid_byp", {63'd0, out_valid_b}, 64'd1);
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [63:0] s, input bit push,
                        input logic [63:0] e1, input logic [63:0] e0);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_state = s;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end else if (push) begin
            sb_q.push_back('{e1, e0});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = {$urandom, $urandom};
    endtask

    // Counts rising edges from the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t        tbl[5];
        int          lat;
        logic [63:0] bs[3];
        int          acc[3];
        int          t;
        int          k;

        tbl[0] = '{64'h0000_0000_0000_0000, 64'hCCCC_CCCC_CCCC_CCCC, 64'hCCCC_CCCC_CCCC_CCCC};
        tbl[1] = '{64'h0123_4567_89AB_CDEF, 64'h6024_1985_FBE7_AD3C, 64'hCAD3_EBF7_8915_0246};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h6666_6666_6666_6666, 64'h6666_6666_6666_6666};
        tbl[3] = '{64'hFEDC_BA98_7654_3210, 64'hC3DA_BF7E_9158_4206, 64'h6420_5198_7FBE_3DAC};
        tbl[4] = '{64'h1000_0000_0000_0000, 64'hCCCC_CCCC_CCCC_CCCA, 64'hACCC_CCCC_CCCC_CCCC};

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_busy",     {63'd0, busy},     64'd0);

        // Latency and release timing on the all-zero state
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(tbl[0].din, 1'b1, tbl[0].exp_pn, tbl[0].exp_byp);
        wait_out(lat);
        chk("latency0", 64'(lat), 64'd4);
        @(posedge clk);
        @(negedge clk);
        chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
        chk("in_ready_back",  {63'd0, in_ready},  64'd1);
        @(posedge clk);
        #1;

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].din, 1'b1, tbl[i].exp_pn, tbl[i].exp_byp);
            wait_out(lat);
            chk("latency_tbl", 64'(lat), 64'd4);
            @(posedge clk);
            #1;
        end

        // Backpressure: 10 stalled cycles with in_valid pressing
        out_ready = 1'b0;
        send(tbl[1].din, 1'b1, tbl[1].exp_pn, tbl[1].exp_byp);
        wait_out(lat);
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid",    {63'd0, out_valid}, 64'd1);
            chk("stall_state",    out_state,          tbl[1].exp_pn);
            chk("stall_in_ready", {63'd0, in_ready},  64'd0);
            chk("stall_busy",     {63'd0, busy},      64'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_state = {$urandom, $urandom};
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("stall_done_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Input churn during SUB is ignored
        send(tbl[3].din, 1'b1, tbl[3].exp_pn, tbl[3].exp_byp);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_state = {$urandom, $urandom};
            @(negedge clk);
            chk("sub_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_out(lat);
        @(posedge clk);
        #1;

        // Reset after two lanes; aborted state must never appear
        send(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 64'd0, 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid",    {63'd0, out_valid}, 64'd0);
        chk("midrst_busy",     {63'd0, busy},      64'd0);
        chk("midrst_in_ready", {63'd0, in_ready},  64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_valid",    {63'd0, out_valid}, 64'd0);
        chk("postrst_busy",     {63'd0, busy},      64'd0);
        chk("postrst_in_ready", {63'd0, in_ready},  64'd1);
        @(posedge clk);
        #1;
        send(tbl[4].din, 1'b1, tbl[4].exp_pn, tbl[4].exp_byp);
        wait_out(lat);
        chk("latency_postrst", 64'(lat), 64'd4);
        @(posedge clk);
        #1;

        // Back-to-back stream: accepts every 6 cycles
        for (int i = 0; i < 3; i++) bs[i] = {$urandom, $urandom};
        t = 0;
        k = 0;
        in_valid = 1'b1;
        in_state = bs[0];
        while (k < 3 && t < 100) begin
            @(negedge clk);
            t++;
            if (in_ready) begin
                sb_q.push_back('{model(bs[k], 1'b1), model(bs[k], 1'b0)});
                acc[k] = t;
                k++;
                @(posedge clk);
                #1;
                if (k < 3) in_state = bs[k];
                else       in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (k < 3) begin
            total++;
            bad++;
            $display("FAIL stream_timeout: accepted %0d want 3", k);
        end else begin
            chk("stream_ii_1", 64'(acc[1] - acc[0]), 64'd6);
            chk("stream_ii_2", 64'(acc[2] - acc[1]), 64'd6);
        end

        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired want finish");
        $fatal(1, "watchdog");
    end
endmodule
